// File: rtl/ristretto_pmp_scan.sv
// Sequential PMP checker: one shared match datapath scans one entry per cycle
// for a fetch and a load/store requester. Optional macro: RISTRETTO_PMP_EARLY_EXIT_EN.
module ristretto_pmp_scan #(
  parameter int DataWidth  = 32,
  parameter int AddrWidth  = 32,
  parameter int PMPentries = 16
) (
  input  logic                                   pmpc_clk_i,
  input  logic                                   pmpc_rst_ni,
  input  logic                                   pmpc_curr_pvm_i,
  input  logic [PMPentries/4-1:0][DataWidth-1:0] pmpc_pmpcfg_i,
  input  logic [PMPentries-1:0][AddrWidth-1:0]   pmpc_pmpaddr_i,
  input  logic                                   pmpc_if_req_i,
  input  logic [AddrWidth-1:0]                   pmpc_if_addr_i,
  output logic                                   pmpc_if_ack_o,
  output logic                                   pmpc_if_valid_o,
  output logic                                   pmpc_if_grant_o,
  input  logic                                   pmpc_ls_req_i,
  input  logic [AddrWidth-1:0]                   pmpc_ls_addr_i,
  input  logic                                   pmpc_ls_we_i,
  output logic                                   pmpc_ls_ack_o,
  output logic                                   pmpc_ls_valid_o,
  output logic                                   pmpc_ls_grant_o,
  input  logic                                   pmpc_flush_i,
  output logic                                   pmpc_busy_o
);

  localparam int IdxW    = $clog2(PMPentries);
  localparam int CfgN    = PMPentries / 4;
  localparam int CfgIdxW = (CfgN > 1) ? $clog2(CfgN) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [IdxW-1:0]        r_idx;
  logic                   r_rr_fetch;
  logic                   r_id_ls;
  logic                   r_found;
  logic                   r_grant;
  logic                   r_we;
  logic [AddrWidth-3:0]   r_addr;

  logic                   w_pick_if;
  logic                   w_pick_ls;
  logic                   w_accept;
  logic                   w_last;
  logic                   w_hit;
  logic                   w_perm;
  logic                   w_entry_grant;
  logic                   w_resp;
  logic [CfgIdxW-1:0]     w_cfg_sel;
  logic [DataWidth-1:0]   w_cfg_word;
  logic [7:0]             w_cfg;
  logic [IdxW-1:0]        w_prev_idx;
  logic [AddrWidth-1:0]   w_a;
  logic [AddrWidth-1:0]   w_lo;
  logic [AddrWidth-1:0]   w_hi;
  logic                   w_unused;

  // Address match for one entry. NAPOT mask clears the trailing ones and the
  // first zero above them; an all-ones pmpaddr yields a zero mask (match all).
  function automatic logic f_match(input logic [1:0]           mode,
                                   input logic [AddrWidth-1:0] a,
                                   input logic [AddrWidth-1:0] lo,
                                   input logic [AddrWidth-1:0] hi);
    logic [AddrWidth-1:0] mask;
    logic                 m;
    m    = 1'b0;
    mask = ~(hi ^ (hi + AddrWidth'(1)));
    case (mode)
      2'b01:   m = (lo < hi) && (a >= lo) && (a < hi);
      2'b10:   m = (a == hi);
      2'b11:   m = ((a & mask) == (hi & mask));
      default: m = 1'b0;
    endcase
    return m;
  endfunction

  function automatic logic f_grant(input logic locked,
                                   input logic perm,
                                   input logic mmode);
    return locked ? perm : (perm | mmode);
  endfunction

  // Arbitration and acceptance (IDLE only)
  always_comb begin
    w_pick_if = pmpc_if_req_i && (!pmpc_ls_req_i || r_rr_fetch);
    w_pick_ls = pmpc_ls_req_i && !w_pick_if;
    w_accept  = (r_state == S_IDLE) && !pmpc_flush_i &&
                (pmpc_if_req_i || pmpc_ls_req_i);
  end

  assign pmpc_if_ack_o = w_accept && w_pick_if;
  assign pmpc_ls_ack_o = w_accept && w_pick_ls;

  // Entry decode for the entry under scan
  assign w_cfg_sel  = CfgIdxW'(r_idx >> 2);
  assign w_cfg_word = pmpc_pmpcfg_i[w_cfg_sel];
  assign w_cfg      = w_cfg_word[{r_idx[1:0], 3'b000} +: 8];
  assign w_prev_idx = r_idx - IdxW'(1);
  assign w_hi       = pmpc_pmpaddr_i[r_idx];
  assign w_lo       = (r_idx == '0) ? '0 : pmpc_pmpaddr_i[w_prev_idx];
  assign w_a        = {2'b00, r_addr};
  assign w_last     = (r_idx == IdxW'(PMPentries - 1));

  always_comb begin
    w_hit         = (r_state == S_SCAN) && f_match(w_cfg[4:3], w_a, w_lo, w_hi);
    w_perm        = r_id_ls ? (r_we ? w_cfg[1] : w_cfg[0]) : w_cfg[2];
    w_entry_grant = f_grant(w_cfg[7], w_perm, pmpc_curr_pvm_i);
  end

  assign w_unused = ^{pmpc_if_addr_i[1:0], pmpc_ls_addr_i[1:0], w_cfg[6:5]};

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = S_SCAN;
      end
      S_SCAN: begin
        if (pmpc_flush_i) begin
          w_state_nxt = S_IDLE;
`ifdef RISTRETTO_PMP_EARLY_EXIT_EN
        end else if (w_hit) begin
          w_state_nxt = S_RESP;
`endif
        end else if (w_last) begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Control state: state, scan index, round-robin pointer, registered decision
  always_ff @(posedge pmpc_clk_i or negedge pmpc_rst_ni) begin
    if (!pmpc_rst_ni) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_rr_fetch <= 1'b1;
      r_id_ls    <= 1'b0;
      r_found    <= 1'b0;
      r_grant    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_idx      <= '0;
            r_id_ls    <= w_pick_ls;
            r_rr_fetch <= w_pick_ls;
            r_found    <= 1'b0;
            r_grant    <= 1'b0;
          end
        end
        S_SCAN: begin
          r_idx <= (pmpc_flush_i || w_state_nxt != S_SCAN) ? '0 : r_idx + IdxW'(1);
          if (!r_found && w_hit) begin
            r_found <= 1'b1;
            r_grant <= w_entry_grant;
          end else if (!r_found && w_last) begin
            r_grant <= pmpc_curr_pvm_i;
          end
        end
        default: r_idx <= '0;
      endcase
    end
  end

  // Request payload captured at the ack edge; the requester may then move on
  always_ff @(posedge pmpc_clk_i) begin
    if (w_accept) begin
      r_addr <= w_pick_ls ? pmpc_ls_addr_i[AddrWidth-1:2] : pmpc_if_addr_i[AddrWidth-1:2];
      r_we   <= w_pick_ls && pmpc_ls_we_i;
    end
  end

  assign w_resp          = (r_state == S_RESP) && !pmpc_flush_i;
  assign pmpc_if_valid_o = w_resp && !r_id_ls;
  assign pmpc_ls_valid_o = w_resp && r_id_ls;
  assign pmpc_if_grant_o = pmpc_if_valid_o && r_grant;
  assign pmpc_ls_grant_o = pmpc_ls_valid_o && r_grant;
  assign pmpc_busy_o     = (r_state != S_IDLE);

endmodule

// File: tb/tb_ristretto_pmp_scan.sv
// Scoreboard bench for ristretto_pmp_scan: driver pushes expected responses,
// a negedge monitor pops and compares requester, grant and arrival cycle.
module tb_ristretto_pmp_scan;

  localparam int N = 16;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 pvm = 1'b0;
  logic [3:0][31:0]     pmpcfg = '0;
  logic [N-1:0][31:0]   pmpaddr = '0;
  logic                 if_req = 1'b0;
  logic [31:0]          if_addr = '0;
  logic                 if_ack, if_valid, if_grant;
  logic                 ls_req = 1'b0;
  logic [31:0]          ls_addr = '0;
  logic                 ls_we = 1'b0;
  logic                 ls_ack, ls_valid, ls_grant;
  logic                 flush = 1'b0;
  logic                 busy;

  typedef struct {
    int   id;
    logic g;
    int   due;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  ristretto_pmp_scan #(.DataWidth(32), .AddrWidth(32), .PMPentries(N)) dut (
    .pmpc_clk_i      (clk),
    .pmpc_rst_ni     (rst_n),
    .pmpc_curr_pvm_i (pvm),
    .pmpc_pmpcfg_i   (pmpcfg),
    .pmpc_pmpaddr_i  (pmpaddr),
    .pmpc_if_req_i   (if_req),
    .pmpc_if_addr_i  (if_addr),
    .pmpc_if_ack_o   (if_ack),
    .pmpc_if_valid_o (if_valid),
    .pmpc_if_grant_o (if_grant),
    .pmpc_ls_req_i   (ls_req),
    .pmpc_ls_addr_i  (ls_addr),
    .pmpc_ls_we_i    (ls_we),
    .pmpc_ls_ack_o   (ls_ack),
    .pmpc_ls_valid_o (ls_valid),
    .pmpc_ls_grant_o (ls_grant),
    .pmpc_flush_i    (flush),
    .pmpc_busy_o     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat(input int k);
`ifdef RISTRETTO_PMP_EARLY_EXIT_EN
    if (k >= 0) return k + 2;
`endif
    return N + 1;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    chk("if_grant_gated", int'(if_grant && !if_valid), 0);
    chk("ls_grant_gated", int'(ls_grant && !ls_valid), 0);
    if (if_valid || ls_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("valid_requester", int'(ls_valid) * 2 + int'(if_valid), (e.id == 1) ? 2 : 1);
        chk("grant", int'(if_valid ? if_grant : ls_grant), int'(e.g));
        chk("valid_cycle", cyc, e.due);
      end
    end
  end

  task automatic wait_drain();
    for (int n = 0; n < 40 && sb.size() != 0; n++) @(negedge clk);
    chk("response_timeout", sb.size(), 0);
    sb.delete();
    @(negedge clk);
  endtask

  task automatic issue(input int id, input logic [31:0] addr, input logic we,
                       input logic g, input int k);
    bit got;
    exp_t e;
    got = 1'b0;
    @(negedge clk);
    if (id == 0) begin
      if_req = 1'b1; if_addr = addr;
    end else begin
      ls_req = 1'b1; ls_addr = addr; ls_we = we;
    end
    for (int n = 0; n < 20 && !got; n++) begin
      #1;
      if ((id == 0) ? if_ack : ls_ack) begin
        got = 1'b1;
        e.id = id; e.g = g; e.due = cyc + lat(k);
        sb.push_back(e);
      end else begin
        @(negedge clk);
      end
    end
    chk("ack_seen", int'(got), 1);
    @(negedge clk);
    chk("busy_in_scan", int'(busy), 1);
    if_req = 1'b0; ls_req = 1'b0;
    if_addr = 32'hDEAD_BEEC; ls_addr = 32'hDEAD_BEEC; ls_we = ~we;
    wait_drain();
  endtask

  task automatic clear_pmp();
    pmpcfg = '0; pmpaddr = '0;
  endtask

  task automatic start_and_reach_t3(output bit got);
    got = 1'b0;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h4000_0FFC;
    for (int n = 0; n < 20 && !got; n++) begin
      #1;
      if (if_ack) got = 1'b1;
      else @(negedge clk);
    end
    chk("ack_seen", int'(got), 1);
    @(negedge clk);
    if_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    bit   got;
    int   n_ack;
    exp_t e;
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(if_valid | ls_valid), 0);
    chk("rst_grant", int'(if_grant | ls_grant), 0);
    chk("rst_ack", int'(if_ack | ls_ack), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // NAPOT entry 0, execute only, U-mode
    clear_pmp();
    pvm = 1'b0;
    pmpaddr[0] = 32'h1000_01FF; pmpcfg[0] = 32'h0000_001C;
    issue(0, 32'h4000_0FFC, 1'b0, 1'b1, 0);
    issue(0, 32'h4000_1000, 1'b0, 1'b0, -1);
    issue(1, 32'h4000_0FFC, 1'b0, 1'b0, 0);

    // TOR entry 2, read only, U-mode
    clear_pmp();
    pmpaddr[1] = 32'h0000_1000; pmpaddr[2] = 32'h0000_2000; pmpcfg[0] = 32'h0009_0000;
    issue(1, 32'h0000_4000, 1'b0, 1'b1, 2);
    issue(1, 32'h0000_8000, 1'b0, 1'b0, -1);
    issue(1, 32'h0000_4000, 1'b1, 1'b0, 2);
    issue(1, 32'h0000_3FFC, 1'b0, 1'b0, -1);

    // NA4 entry 3, M-mode stores
    clear_pmp();
    pvm = 1'b1;
    pmpaddr[3] = 32'h0000_0400; pmpcfg[0] = 32'h9100_0000;
    issue(1, 32'h0000_1000, 1'b1, 1'b0, 3);
    pmpcfg[0] = 32'h1100_0000;
    issue(1, 32'h0000_1000, 1'b1, 1'b1, 3);
    clear_pmp();
    issue(1, 32'h0000_1000, 1'b1, 1'b1, -1);

    // Entry 5 NA4 readable ahead of entry 6 NAPOT match-all with no permissions
    clear_pmp();
    pvm = 1'b0;
    pmpaddr[5] = 32'h0000_0040; pmpaddr[6] = 32'hFFFF_FFFF;
    pmpcfg[1] = 32'h0018_1100;
    issue(1, 32'h0000_0100, 1'b0, 1'b1, 5);
    issue(1, 32'h0000_0200, 1'b0, 1'b0, 6);

    // TOR at entry 0 uses zero as lower bound
    clear_pmp();
    pmpaddr[0] = 32'h0000_0010; pmpcfg[0] = 32'h0000_000C;
    issue(0, 32'h0000_0000, 1'b0, 1'b1, 0);
    issue(0, 32'h0000_0040, 1'b0, 1'b0, -1);

    // Flush held in IDLE suppresses ack
    @(negedge clk);
    flush = 1'b1; if_req = 1'b1; if_addr = 32'h0000_0000;
    #1 chk("flush_idle_ack", int'(if_ack), 0);
    @(negedge clk);
    #1 chk("flush_idle_ack", int'(if_ack | busy), 0);
    flush = 1'b0; if_req = 1'b0;
    issue(0, 32'h0000_0004, 1'b0, 1'b1, 0);

    // Flush at T3: no valid, idle at T4
    clear_pmp();
    pmpaddr[0] = 32'h1000_01FF; pmpcfg[0] = 32'h0000_001C;
    start_and_reach_t3(got);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1 chk("flush_busy_t4", int'(busy), 0);
    repeat (N + 4) @(negedge clk);

    // Reset mid-scan clears everything at once
    start_and_reach_t3(got);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_valid", int'(if_valid | ls_valid), 0);
    chk("midrst_grant", int'(if_grant | ls_grant), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (N + 4) @(negedge clk);

    // Round-robin from reset: fetch, ls, fetch
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h4000_0FFC;
    ls_req = 1'b1; ls_addr = 32'h4000_0FFC; ls_we = 1'b0;
    n_ack = 0;
    for (int n = 0; n < 120 && n_ack < 3; n++) begin
      #1;
      if (if_ack || ls_ack) begin
        chk("single_ack", int'(if_ack && ls_ack), 0);
        chk("rr_order", int'(ls_ack), n_ack % 2);
        e.id = ls_ack ? 1 : 0; e.g = ls_ack ? 1'b0 : 1'b1; e.due = cyc + lat(0);
        sb.push_back(e);
        n_ack++;
      end
      @(negedge clk);
    end
    chk("rr_ack_count", n_ack, 3);
    if_req = 1'b0; ls_req = 1'b0;
    wait_drain();

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ristretto_pmp_scan.md
RISTRETTO_PMP_SCAN -- requirements
Module: ristretto_pmp_scan

Interface
REQ-001 SHALL have parameters: DataWidth, 32, CSR width; AddrWidth, 32, address width; PMPentries, 16, number of PMP entries (a multiple of 4).
REQ-002 SHALL have ports in this order:
- pmpc_clk_i  in  1  clock; one clock domain only.
- pmpc_rst_ni  in  1  reset; asynchronous, active-low.
- pmpc_curr_pvm_i  in  1  privilege: 1 = M-mode, 0 = U-mode.
- pmpc_pmpcfg_i  in  DataWidth x PMPentries/4  pmpcfg CSRs.
- pmpc_pmpaddr_i  in  AddrWidth x PMPentries  pmpaddr CSRs.
- pmpc_if_req_i, pmpc_if_addr_i  in  1, AddrWidth  fetch request and fetch address.
- pmpc_if_ack_o, pmpc_if_valid_o, pmpc_if_grant_o  out  1 each  fetch accept, fetch result strobe, fetch result (execute permission).
- pmpc_ls_req_i, pmpc_ls_addr_i, pmpc_ls_we_i  in  1, AddrWidth, 1  load/store request, address, store flag.
- pmpc_ls_ack_o, pmpc_ls_valid_o, pmpc_ls_grant_o  out  1 each  load/store accept, result strobe, result.
- pmpc_flush_i  in  1  abort the check in progress.
- pmpc_busy_o  out  1  high when state is not IDLE; the CSR unit stalls pmp CSR writes while it is high.

Function
REQ-003 SHALL implement states IDLE, SCAN and RESP, one PMP entry checked per SCAN cycle, so a single shared match datapath serves both requesters.
REQ-004 In IDLE, with pmpc_flush_i low and at least one request pending, the block SHALL assert exactly one ack for one cycle, combinationally in that cycle.
REQ-005 The accepted request SHALL have its address, we and requester id latched at the end of the ack cycle (T0); the next state SHALL be SCAN with index 0 at T1.
REQ-006 Arbitration SHALL be round-robin: when both requests are high, the requester not served last wins; after reset, fetch wins.
REQ-007 Entry decode per cycle:
- cfg byte i = pmpcfg[i/4][8*(i%4)+7 : 8*(i%4)]; A = cfg[4:3]; L = cfg[7]; X = cfg[2]; W = cfg[1]; R = cfg[0].
- Comparisons SHALL use a = addr[AddrWidth-1:2].
- OFF: no match.
- TOR: pmpaddr[i-1] <= a < pmpaddr[i], unsigned; lower bound is 0 for i = 0; no match if lower >= upper.
- NA4: a == pmpaddr[i].
- NAPOT: t = number of trailing ones of pmpaddr[i]; match when a and pmpaddr[i] agree above bit t. All-ones pmpaddr matches everything.
REQ-008 Permission SHALL be X for fetch, W for a load/store with we=1, and R for a load/store with we=0.
REQ-009 Grant rules:
- Match with L=1: grant = permission bit.
- Match with L=0: grant = permission bit in U-mode, 1 in M-mode.
- No match: grant = pmpc_curr_pvm_i.
REQ-010 The lowest-indexed matching entry SHALL decide the result; the decision SHALL be registered.
REQ-011 SCAN SHALL go to RESP after index PMPentries-1, and also on first match when early exit is compiled in (REQ-016).
REQ-012 In RESP, for exactly one cycle, the served requester's valid_o SHALL be 1 and its grant_o SHALL hold the decision; the next state SHALL be IDLE.
- grant_o SHALL be 0 whenever valid_o is 0.
- No ack SHALL be issued in SCAN or RESP.
REQ-013 pmpc_flush_i in SCAN or RESP SHALL force IDLE on the next edge with no valid pulse; flush in IDLE SHALL suppress ack.
REQ-014 Privilege and CSR inputs SHALL be sampled live each SCAN cycle; the address SHALL come from the latched copy only, so the request address may change after ack.

Reset
REQ-015 Reset SHALL be asynchronous on pmpc_rst_ni low and SHALL give: state IDLE, index 0, round-robin pointer = fetch, all ack/valid/grant outputs 0, pmpc_busy_o 0. Reset during SCAN SHALL drop the check with no valid pulse.

Configuration
REQ-016 Macro RISTRETTO_PMP_EARLY_EXIT_EN SHALL select the result timing:
- Defined: SCAN exits on the first match; a match at entry k gives valid at T(k+2).
- Undefined: all PMPentries entries are always scanned (constant time); valid at T(PMPentries+1).
- No match: valid at T(PMPentries+1) in both builds.
- The grant value SHALL be identical in both builds.

Verification
REQ-017 U-mode fetch, entry0 NAPOT pmpaddr=0x100001FF cfg=0x1C (X=1), addr 0x40000FFC -> if_grant=1; addr 0x40001000 -> if_grant=0.
REQ-018 U-mode load, entry2 TOR pmpaddr1=0x1000, pmpaddr2=0x2000, cfg=0x09 (R=1): addr 0x4000 -> ls_grant=1; addr 0x8000 -> ls_grant=0; with we=1 at 0x4000 -> ls_grant=0.
REQ-019 M-mode store, entry3 NA4 pmpaddr=0x400 cfg=0x91 (L=1, W=0), addr 0x1000 -> ls_grant=0; same entry with L=0 -> ls_grant=1; no entries programmed -> ls_grant=1.
REQ-020 if_req and ls_req held high together from reset -> acks alternate fetch, ls, fetch; each valid arrives on its own requester only.
REQ-021 Flush asserted at T3 of a scan -> no valid pulse, busy_o=0 at T4; a reset pulse mid-SCAN -> all outputs 0 immediately.
REQ-022 Timing, match at entry 5 of 16: valid at T7 with RISTRETTO_PMP_EARLY_EXIT_EN, at T17 without; same grant value in both builds.
